// File: rtl/aes_round_ctrl.sv
// AES block sequencer: loads 16 plaintext bytes, steps rounds 0..NR against a
// round-key handshake, then streams the 16-byte result out MSB-first.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       state_mode,
  output logic       state_valid,
  output logic       state_wen,
  output logic [3:0] round_idx,
  output logic [1:0] round_type,
  output logic       key_req,
  input  logic       key_ack,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_byte_sel,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {
    StLoad,
    StRound,
    StUnload
  } st_e;

  st_e        st_q;
  logic [3:0] load_cnt_q;
  logic [3:0] round_q;
  logic [3:0] sel_q;
  logic       done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StLoad;
      load_cnt_q <= 4'd0;
      round_q    <= 4'd0;
      sel_q      <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        StLoad: begin
          // in_ready is high throughout LOAD, so in_valid alone is an accept.
          if (in_valid) begin
            load_cnt_q <= load_cnt_q + 4'd1;
            if (load_cnt_q == 4'd15) begin
              st_q    <= StRound;
              round_q <= 4'd0;
            end
          end
        end
        StRound: begin
          if (key_ack) begin
            if (round_q == LastRound) begin
              st_q    <= StUnload;
              round_q <= 4'd0;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        StUnload: begin
          if (out_ready) begin
            sel_q <= sel_q + 4'd1;
            if (sel_q == 4'd15) begin
              st_q   <= StLoad;
              done_q <= 1'b1;
            end
          end
        end
        default: st_q <= StLoad;
      endcase
    end
  end

  assign in_ready     = (st_q == StLoad);
  assign state_mode   = (st_q != StLoad);
  assign state_valid  = in_valid & in_ready;
  assign key_req      = (st_q == StRound);
  // Round commit is a same-cycle decode of the key handshake.
  assign state_wen    = key_req & key_ack;
  assign out_valid    = (st_q == StUnload);
  assign busy         = !((st_q == StLoad) && (load_cnt_q == 4'd0));
  assign round_idx    = round_q;
  assign out_byte_sel = sel_q;
  assign done         = done_q;

  always_comb begin
    round_type = 2'd1;
    if (round_q == 4'd0) begin
      round_type = 2'd0;
    end else if (round_q == LastRound) begin
      round_type = 2'd2;
    end
  end

endmodule
